i2c_write_master: RTL and testbench

Single-register I2C write engine that consumes the divided `i2c_clk` produced by the I2C clock divider and turns it into bus-level SCL/SDA activity. It runs entirely in the `ref_clk` domain. It treats `i2c_clk` as a slow data input and uses its edges as quarter-bit phase ticks. One accepted request produces START, address+W, register byte, data byte and STOP, with ACK checking after each byte.

---
 rtl/i2c_write_master_if.sv | 25 ++
 rtl/i2c_write_master.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_write_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_master_if.sv
// Request/status handshake and I2C pad signals of the write engine.
interface i2c_write_master_if;
  logic       start;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       sda_i;
  logic       scl_o;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       nack_err;

  // Engine side: takes the request and the sensed SDA, drives the pads and status.
  modport master (
    input  start, dev_addr, reg_addr, wr_data, sda_i,
    output scl_o, sda_oe, busy, done, nack_err
  );

  // Requester / bus side.
  modport slave (
    output start, dev_addr, reg_addr, wr_data, sda_i,
    input  scl_o, sda_oe, busy, done, nack_err
  );
endinterface

// File: rtl/i2c_write_master.sv
// Single-register I2C write engine: START, addr+W, reg, data, STOP, with ACK checks.
// i2c_clk is only a phase source; both of its edges become quarter-bit ticks.
module i2c_write_master #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              i2c_clk,
  i2c_write_master_if.master bus
);

  localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned PH_W   = 2;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(3);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(7);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  logic [SYNC_W-1:0] sync_q;
  logic              prev_q;
  logic              qtick_q;

  state_t            state_q,  state_d;
  logic [PH_W-1:0]   phase_q,  phase_d;
  logic [BIT_W-1:0]  bit_q,    bit_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [BYTE_W-1:0] addr_q,   addr_d;
  logic [BYTE_W-1:0] reg_q,    reg_d;
  logic [BYTE_W-1:0] data_q,   data_d;
  logic              scl_q,    scl_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              nack_q,   nack_d;

  logic [BYTE_W-1:0] cur_byte;
  logic [PH_W-1:0]   phase_inc;

  // Synchronize i2c_clk and turn either edge into a one-cycle qtick.
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      qtick_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_W-2:0], i2c_clk};
      prev_q  <= sync_q[SYNC_W-1];
      qtick_q <= sync_q[SYNC_W-1] ^ prev_q;
    end
  end

  // State, datapath and registered pad/status outputs.
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      reg_q    <= '0;
      data_q   <= '0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
    end
  end

  // Byte currently being shifted out, and the wrapping phase increment.
  always_comb begin
    cur_byte  = data_q;
    phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    case (idx_q)
      IDX_W'(0): cur_byte = addr_q;
      IDX_W'(1): cur_byte = reg_q;
      default:   cur_byte = data_q;
    endcase
  end

  // Next-state and output sequencing; bus activity only advances on qtick.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    reg_d    = reg_q;
    data_d   = data_q;
    scl_d    = scl_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    nack_d   = nack_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d  = {bus.dev_addr, 1'b0};
          reg_d   = bus.reg_addr;
          data_d  = bus.wr_data;
          busy_d  = 1'b1;
          nack_d  = 1'b0;
          phase_d = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (qtick_q) begin
          phase_d = phase_inc;
          case (phase_q)
            PH_W'(0): begin
              scl_d    = 1'b1;
              sda_oe_d = 1'b0;
            end
            PH_W'(1): sda_oe_d = 1'b1;
            PH_W'(3): begin
              scl_d   = 1'b0;
              idx_d   = '0;
              bit_d   = BIT_MSB;
              state_d = ST_BYTE;
            end
            default: ;
          endcase
        end
      end

      ST_BYTE: begin
        if (qtick_q) begin
          phase_d = phase_inc;
          case (phase_q)
            PH_W'(0): sda_oe_d = ~cur_byte[bit_q];
            PH_W'(1): scl_d = 1'b1;
            PH_W'(3): begin
              scl_d = 1'b0;
              if (bit_q == '0) begin
                bit_d   = BIT_MSB;
                state_d = ST_ACK;
              end else begin
                bit_d = bit_q - BIT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end

      ST_ACK: begin
        if (qtick_q) begin
          phase_d = phase_inc;
          case (phase_q)
            PH_W'(0): sda_oe_d = 1'b0;
            PH_W'(1): scl_d = 1'b1;
            PH_W'(2): if (bus.sda_i) nack_d = 1'b1;
            PH_W'(3): begin
              scl_d = 1'b0;
              if (nack_q || (idx_q == IDX_LAST)) begin
                state_d = ST_STOP;
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                bit_d   = BIT_MSB;
                state_d = ST_BYTE;
              end
            end
            default: ;
          endcase
        end
      end

      ST_STOP: begin
        if (qtick_q) begin
          phase_d = phase_inc;
          case (phase_q)
            PH_W'(0): sda_oe_d = 1'b1;
            PH_W'(1): scl_d = 1'b1;
            PH_W'(2): sda_oe_d = 1'b0;
            PH_W'(3): begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_DONE;
            end
            default: ;
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.scl_o    = scl_q;
  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.nack_err = nack_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus-level decoder/slave model with a byte scoreboard.
module tb_i2c_write_master;

  logic ref_clk = 1'b0;
  logic reset   = 1'b0;
  logic i2c_clk = 1'b0;

  i2c_write_master_if bus();

  i2c_write_master #(.SYNC_STAGES(2)) dut (
    .ref_clk (ref_clk),
    .reset   (reset),
    .i2c_clk (i2c_clk),
    .bus     (bus)
  );

  // 10 ns ref_clk; i2c_clk edges every 8 ref_clk cycles -> qtick spacing 8 cycles.
  always #5  ref_clk = ~ref_clk;
  always #80 i2c_clk = ~i2c_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: open-drain wired-AND with the master, ACK per nack_mask.
  logic       slave_pull = 1'b0;
  logic [7:0] nack_mask  = 8'h00;
  assign bus.sda_i = ~(bus.sda_oe | slave_pull);

  logic [7:0] exp_q[$];

  int cyc = 0;
  always @(posedge ref_clk) cyc++;

  // Decoder state (written only by the decoder process).
  logic       prev_scl  = 1'b1;
  logic       prev_line = 1'b1;
  logic       prev_done = 1'b0;
  logic       in_ack    = 1'b0;
  logic [7:0] shreg     = 8'h00;
  int bitcnt = 0, byte_no = 0;
  int rises = 0, stops = 0, start_t = 0, stop_t = 0;
  int done_pulses = 0, done_hi = 0, done_t = 0;
  logic busy_at_done = 1'b0;

  // Baselines snapshotted by the stimulus process.
  int b_rises = 0, b_stops = 0, b_done = 0, b_dhi = 0;

  // Bus decoder: START/STOP detection, bit capture on SCL rise, ACK drive.
  always @(negedge ref_clk) begin : decoder
    logic line;
    line = bus.sda_i;
    if (bus.scl_o && prev_scl && prev_line && !line) begin
      start_t = cyc;
      bitcnt  = 0;
      byte_no = 0;
      in_ack  = 1'b0;
    end else if (bus.scl_o && prev_scl && !prev_line && line) begin
      stops++;
      stop_t = cyc;
    end
    if (bus.scl_o && !prev_scl) begin
      rises++;
      if (!in_ack && bitcnt < 8) begin
        shreg = {shreg[6:0], line};
        bitcnt++;
        if (bitcnt == 8) begin
          chk("byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk($sformatf("byte%0d", byte_no), 32'(shreg), 32'(exp_q.pop_front()));
        end
      end
    end
    if (!bus.scl_o && prev_scl) begin
      if (in_ack) begin
        in_ack     = 1'b0;
        slave_pull = 1'b0;
        bitcnt     = 0;
        byte_no++;
      end else if (bitcnt == 8) begin
        in_ack     = 1'b1;
        slave_pull = ~nack_mask[byte_no];
      end
    end
    if (bus.done) begin
      done_hi++;
      if (!prev_done) begin
        done_pulses++;
        done_t       = cyc;
        busy_at_done = bus.busy;
      end
    end
    prev_scl  = bus.scl_o;
    prev_line = line;
    prev_done = bus.done;
  end

  task automatic launch(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d,
                        input logic [2:0] nm);
    @(negedge ref_clk);
    b_rises = rises; b_stops = stops; b_done = done_pulses; b_dhi = done_hi;
    nack_mask    = {5'b0, nm};
    bus.dev_addr = a;
    bus.reg_addr = r;
    bus.wr_data  = d;
    exp_q.push_back({a, 1'b0});
    if (!nm[0]) begin
      exp_q.push_back(r);
      if (!nm[1]) exp_q.push_back(d);
    end
    bus.start = 1'b1;
    @(negedge ref_clk);
    bus.start = 1'b0;
    chk("busy_on_accept", 32'(bus.busy), 1);
  endtask

  task automatic finish_txn(input int exp_rises, input int exp_span, input logic exp_nack);
    int k;
    k = 0;
    while (!bus.done && k < 3000) begin
      @(negedge ref_clk);
      k++;
    end
    chk("done_seen", 32'(bus.done), 1);
    repeat (4) @(negedge ref_clk);
    chk("done_pulses",   32'(done_pulses - b_done), 1);
    chk("done_width",    32'(done_hi - b_dhi), 1);
    chk("busy_at_done",  32'(busy_at_done), 0);
    chk("busy_after",    32'(bus.busy), 0);
    chk("nack_err",      32'(bus.nack_err), 32'(exp_nack));
    chk("scl_rises",     32'(rises - b_rises), 32'(exp_rises));
    chk("stop_count",    32'(stops - b_stops), 1);
    chk("start_to_stop", 32'(stop_t - start_t), 32'(exp_span));
    chk("stop_to_done",  32'(done_t - stop_t), 8);
    chk("bytes_left",    32'(exp_q.size()), 0);
    chk("idle_lines",    32'({bus.scl_o, bus.sda_oe}), 32'(2'b10));
  endtask

  // Hard stop if anything wedges.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    bus.start    = 1'b0;
    bus.dev_addr = '0;
    bus.reg_addr = '0;
    bus.wr_data  = '0;

    // Reset held with i2c_clk running.
    repeat (20) begin
      @(negedge ref_clk);
      chk("reset_hold", 32'({bus.scl_o, bus.sda_oe, bus.busy, bus.done, bus.nack_err}), 32'(5'b10000));
    end
    reset = 1'b1;
    repeat (10) @(negedge ref_clk);

    // Full ACKed write: 113 qticks between START and STOP conditions.
    launch(7'h50, 8'hA5, 8'h3C, 3'b000);
    finish_txn(28, 113 * 8, 1'b0);

    // Address NACK: 9 bit clocks + STOP.
    launch(7'h50, 8'hA5, 8'h3C, 3'b001);
    finish_txn(10, 41 * 8, 1'b1);

    // Data NACK: full length, flag set.
    launch(7'h50, 8'hA5, 8'h3C, 3'b100);
    finish_txn(28, 113 * 8, 1'b1);

    // New accept clears the sticky flag; start mid-transaction is ignored.
    launch(7'h50, 8'hA5, 8'h3C, 3'b000);
    chk("nack_cleared", 32'(bus.nack_err), 0);
    repeat (300) @(negedge ref_clk);
    bus.dev_addr = 7'h11;
    bus.reg_addr = 8'h22;
    bus.wr_data  = 8'h33;
    bus.start    = 1'b1;
    repeat (3) @(negedge ref_clk);
    bus.start = 1'b0;
    finish_txn(28, 113 * 8, 1'b0);

    // Fresh start after done uses the new operands.
    launch(7'h11, 8'h22, 8'h33, 3'b000);
    finish_txn(28, 113 * 8, 1'b0);

    // Reset during a high-SCL bit of the register byte.
    launch(7'h2A, 8'h5A, 8'hC3, 3'b000);
    k = 0;
    while (!(byte_no == 1 && bitcnt >= 3 && bus.scl_o) && k < 3000) begin
      @(negedge ref_clk);
      k++;
    end
    chk("mid_byte_reached", 32'(byte_no == 1 && bitcnt >= 3 && bus.scl_o), 1);
    @(posedge ref_clk);
    #2 reset = 1'b0;
    #1 chk("rst_async", 32'({bus.scl_o, bus.sda_oe, bus.busy, bus.done, bus.nack_err}), 32'(5'b10000));
    exp_q.delete();
    repeat (5) @(negedge ref_clk);
    reset = 1'b1;
    repeat (100) @(negedge ref_clk);
    chk("rst_no_done", 32'(done_pulses - b_done), 0);
    chk("rst_idle", 32'({bus.scl_o, bus.sda_oe, bus.busy}), 32'(3'b100));

    // Recovery with boundary operand values.
    launch(7'h7F, 8'hFF, 8'h00, 3'b000);
    finish_txn(28, 113 * 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
